// File: rtl/ms_pkg.sv
// ms_pkg: shared types and defaults for the ms_arbiter slice (slave beat types,
// arbiter state encoding, default burst/timeout limits).
package ms_pkg;

  localparam int unsigned MS_ADDR_W        = 2;
  localparam int unsigned MS_DATA_W        = 8;
  localparam int unsigned MS_NUM_REQ_DEF   = 4;
  localparam int unsigned MS_MAX_BURST_DEF = 4;
  localparam int unsigned MS_TIMEOUT_DEF   = 16;

  typedef logic [MS_ADDR_W-1:0] ms_addr_t;
  typedef logic [MS_DATA_W-1:0] ms_data_t;

  // One beat as seen by the slave.
  typedef struct packed {
    ms_addr_t addr;
    ms_data_t data;
  } ms_beat_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned ms_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_arbiter_if.sv
// ms_arbiter_if: requester bundle plus the shared slave beat port. 'slave' is the
// arbiter's view, 'master' the view of the masters and slave device around it.
interface ms_arbiter_if
  import ms_pkg::*;
#(
  parameter int unsigned NUM_REQ = MS_NUM_REQ_DEF
) ();

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*MS_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*MS_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           ack;
  logic                         m_valid;
  ms_addr_t                     m_addr;
  ms_data_t                     m_data;
  logic                         s_ready;

`ifdef MS_ARB_TIMEOUT_EN
  logic                         err;

  modport master (
    output req, req_addr, req_data, s_ready,
    input  gnt, ack, m_valid, m_addr, m_data, err
  );

  modport slave (
    input  req, req_addr, req_data, s_ready,
    output gnt, ack, m_valid, m_addr, m_data, err
  );
`else
  modport master (
    output req, req_addr, req_data, s_ready,
    input  gnt, ack, m_valid, m_addr, m_data
  );

  modport slave (
    input  req, req_addr, req_data, s_ready,
    output gnt, ack, m_valid, m_addr, m_data
  );
`endif

endinterface

// File: rtl/ms_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search; returns the first set request at or
// after i_ptr (wrapping modulo NUM_REQ).
module rr_pick
  import ms_pkg::*;
#(
  parameter  int unsigned NUM_REQ = MS_NUM_REQ_DEF,
  localparam int unsigned IW      = ms_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic               o_valid,
  output logic [IW-1:0]      o_idx
);

  logic [IW-1:0] w_pos [NUM_REQ];

  // Candidate index at each search offset; ptr+g stays below 2*NUM_REQ.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pos
    logic [IW:0] w_sum;
    assign w_sum    = {1'b0, i_ptr} + (IW+1)'(g);
    assign w_pos[g] = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ))
                                                  : IW'(w_sum);
  end

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[w_pos[i]]) begin
        o_valid = 1'b1;
        o_idx   = w_pos[i];
      end
    end
  end

endmodule

// File: rtl/ms_arbiter.sv
// ms_arbiter: round-robin arbiter sharing one slave beat port among NUM_REQ masters
// with bounded bursts. Optional stall timeout and err pulse under MS_ARB_TIMEOUT_EN.
module ms_arbiter
  import ms_pkg::*;
#(
  parameter int unsigned NUM_REQ   = MS_NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MS_MAX_BURST_DEF
`ifdef MS_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = MS_TIMEOUT_DEF
`endif
) (
  input  logic         clk,
  input  logic         rstn,
  ms_arbiter_if.slave  bus
);

  localparam int unsigned IW = ms_idx_w(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_e          r_state;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       r_ptr;
  logic [CW-1:0]       r_cnt;
  logic [NUM_REQ-1:0]  r_gnt;

  logic                w_pick_vld;
  logic [IW-1:0]       w_pick_idx;
  logic [IW-1:0]       w_pick_nxt;
  logic                w_busy;
  logic                w_own_req;
  logic                w_valid;
  logic                w_beat;
  logic                w_last;
  logic                w_tmo;
  logic                w_release;
  ms_beat_t            w_slot [NUM_REQ];
  ms_beat_t            w_out;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  // Unpack the per-master address/data into beat slots.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign w_slot[g] = {bus.req_addr[g*MS_ADDR_W +: MS_ADDR_W],
                        bus.req_data[g*MS_DATA_W +: MS_DATA_W]};
  end

  assign w_busy     = (r_state == BUSY);
  assign w_own_req  = bus.req[r_owner];
  assign w_valid    = rstn & w_busy & w_own_req;
  assign w_beat     = w_valid & bus.s_ready;
  assign w_last     = (r_cnt == CW'(MAX_BURST - 1));
  assign w_release  = w_busy & ((w_beat & w_last) | ~w_own_req | w_tmo);
  assign w_pick_nxt = (w_pick_idx == IW'(NUM_REQ - 1)) ? '0 : w_pick_idx + IW'(1);
  assign w_out      = w_busy ? w_slot[r_owner] : '0;

  assign bus.gnt     = r_gnt;
  assign bus.ack     = w_beat ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.m_valid = w_valid;
  assign bus.m_addr  = w_out.addr;
  assign bus.m_data  = w_out.data;

`ifdef MS_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] r_stall;
  logic          w_stall;

  assign w_stall = w_valid & ~bus.s_ready;
  assign w_tmo   = w_stall & (r_stall == SW'(TIMEOUT - 1));
  assign bus.err = w_tmo;

  // Consecutive-stall counter for the current owner.
  always_ff @(posedge clk) begin
    if (!rstn || !w_busy || w_beat || w_tmo) begin
      r_stall <= '0;
    end else if (w_stall) begin
      r_stall <= r_stall + SW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Arbitration FSM: grant in IDLE, count beats and release in BUSY.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state <= BUSY;
            r_owner <= w_pick_idx;
            r_ptr   <= w_pick_nxt;
            r_cnt   <= '0;
            r_gnt   <= NUM_REQ'(1) << w_pick_idx;
          end
        end
        BUSY: begin
          if (w_beat) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (w_release) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt   <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

endmodule
